lock_key_sender: RTL and testbench
==================================

// Module: lock_key_sender
// PURPOSE
//   Initiator side of the serial lock-entry protocol used by lock_fsm.
//   Takes a parallel key code on a start request and drives enter/keyin/valid/
//   lock_reset to clear the lock and shift the code in MSB first.
//   Then samples the lock's unlock/error response and reports pass/fail/timeout.
//   Sits between a user/test controller and the lock FSM, on the same clock.
// PARAMETERS
//   KEY_BITS   3  number of key bits sent, MSB first (lock expects 3)
//   GAP        2  idle cycles (enter=0) after each key-bit cycle; legal range 0..15
//   RESP_WAIT  4  max cycles in RESP waiting for unlock/error; legal range 1..15
// PORTS
//   clk          in   1         single clock, all state on posedge
//   reset        in   1         asynchronous, active-high; clears all state
//   start        in   1         request to send code; sampled only in IDLE
//   code         in   KEY_BITS  key to send; captured when start is accepted
//   lock_unlock  in   1         lock's unlock output
//   lock_error   in   1         lock's error output
//   enter        out  1         enter strobe to lock
//   keyin        out  1         key bit to lock
//   valid        out  1         qualifies lock state update; 1 whenever busy
//   lock_reset   out  1         lock clear, high for the CLR cycle only
//   busy         out  1         1 from CLR through RESP
//   done         out  1         1-cycle pulse, first cycle results are valid
//   pass         out  1         lock reported unlock
//   fail         out  1         lock reported error
//   timeout      out  1         no response within RESP_WAIT cycles
// BEHAVIOUR
//   Reset (async): state=IDLE; all outputs 0; code register, counters, results cleared.
//   Reset mid-operation aborts the sequence immediately.
//   States: IDLE, CLR, ENT, BIT, GAPW, RESP. All outputs are registered or
//   pure state decode; no input-to-output combinational path.
//   IDLE: enter=keyin=valid=lock_reset=busy=0.
//     start=1 -> capture code, clear pass/fail/timeout, bit index=KEY_BITS-1,
//     go to CLR. start is ignored in every state other than IDLE.
//   CLR (1 cyc): valid=1, lock_reset=1, enter=0 -> ENT.
//   ENT (1 cyc): valid=1, enter=1, keyin=0.
//     If fewer than KEY_BITS bits sent -> BIT; else (final enter) -> RESP.
//   BIT (1 cyc): valid=1, enter=0, keyin=code_q[idx].
//     Decrement idx. If GAP=0 -> ENT; else -> GAPW.
//   GAPW (GAP cyc): valid=1, enter=0, keyin=0 -> ENT.
//   Sequence: CLR,ENT,BIT(MSB),GAP,ENT,BIT,GAP,...,ENT.
//     Total enter pulses = KEY_BITS+1.
//     Cycles CLR..final ENT = 2 + KEY_BITS*(2+GAP).
//   RESP: valid=1, enter=0. Sample lock_unlock/lock_error each cycle.
//     error=1 -> fail=1 (error wins if both high).
//     else unlock=1 -> pass=1.
//     Neither after RESP_WAIT cycles -> timeout=1.
//     On any outcome -> IDLE next cycle, with done=1 in that cycle.
//     pass/fail/timeout are mutually exclusive and held until the next accepted start.
//   Lock timing: the lock asserts unlock or error in the first RESP cycle;
//     RESP_WAIT>1 is margin only.
//   start asserted in the same cycle as done (IDLE) is accepted.
//   Wrong-bit path needs no special handling: the lock ignores keyin after a
//     mismatch, and the sender still issues all enter pulses.
// TESTING
//   1. GAP=2, lock key 3'b101, code=3'b101, start pulsed in cycle 0.
//      -> lock_reset cycle 1; enter high in cycles 2,6,10,14.
//      -> keyin=1,0,1 in cycles 3,7,11; unlock seen cycle 15.
//      -> done=1 and pass=1 in cycle 16.
//   2. Same as 1 with code=3'b001 (MSB wrong) -> identical enter timing; fail=1 in cycle 16.
//   3. GAP=0, code=3'b110 matching lock -> enter in cycles 2,4,6,8; pass=1 in cycle 10.
//   4. lock_unlock/lock_error tied 0, RESP_WAIT=4.
//      -> timeout=1 and done pulse after 4 RESP cycles; pass=fail=0.
//   5. reset asserted asynchronously during GAPW.
//      -> all outputs 0 immediately; a new start runs a full clean sequence with pass.
//   6. start held high through a whole run -> second sequence begins in the done cycle.
//      Code changes while busy have no effect on keyin.

Source files
------------

// File: rtl/lock_key_sender.sv
// Serial key sender for lock_fsm: clears the lock, shifts a code in MSB first,
// then waits for the lock's verdict and reports pass, fail or timeout.
module lock_key_sender #(
    parameter int KEY_BITS  = 3,
    parameter int GAP       = 2,
    parameter int RESP_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KEY_BITS-1:0] code,
    input  logic                lock_unlock,
    input  logic                lock_error,
    output logic                enter,
    output logic                keyin,
    output logic                valid,
    output logic                lock_reset,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout
);

    localparam int IW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE, CLR, ENT, BIT, GAPW, RESP
    } state_t;

    state_t              state_q, state_d;
    logic [KEY_BITS-1:0] code_q, code_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                last_q, last_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                to_q, to_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    code_d  = code;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    to_d    = 1'b0;
                    idx_d   = IW'(KEY_BITS - 1);
                    last_d  = 1'b0;
                    state_d = CLR;
                end
            end
            CLR: state_d = ENT;
            ENT: begin
                cnt_d   = '0;
                state_d = last_q ? RESP : BIT;
            end
            BIT: begin
                // last_q marks that the final key bit has gone out
                if (idx_q == '0) last_d = 1'b1;
                else             idx_d  = idx_q - 1'b1;
                cnt_d   = '0;
                state_d = (GAP == 0) ? ENT : GAPW;
            end
            GAPW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 4'(GAP - 1)) state_d = ENT;
            end
            RESP: begin
                if (lock_error) begin
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (lock_unlock) begin
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 4'(RESP_WAIT - 1)) begin
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter      = (state_q == ENT);
    assign keyin      = (state_q == BIT) & code_q[idx_q];
    assign lock_reset = (state_q == CLR);
    assign valid      = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = to_q;

endmodule

// File: tb/tb_lock_key_sender.sv
// Directed bench for lock_key_sender: GAP=2 (a_*) and GAP=0 (b_*) instances
// share stimulus; the bench plays the lock by driving the verdict at known cycles.
module tb_lock_key_sender;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] code;
    logic       lock_unlock;
    logic       lock_error;

    logic a_enter, a_keyin, a_valid, a_lr, a_busy;
    logic a_done, a_pass, a_fail, a_to;
    logic b_enter, b_keyin, b_valid, b_lr, b_busy;
    logic b_done, b_pass, b_fail, b_to;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] ev, kv, lv, dv, pv, fv, tv, vv;

    always #5 clk = ~clk;

    lock_key_sender #(.KEY_BITS(3), .GAP(2), .RESP_WAIT(4)) u_a (
        .clk(clk), .reset(reset), .start(start), .code(code),
        .lock_unlock(lock_unlock), .lock_error(lock_error),
        .enter(a_enter), .keyin(a_keyin), .valid(a_valid),
        .lock_reset(a_lr), .busy(a_busy), .done(a_done),
        .pass(a_pass), .fail(a_fail), .timeout(a_to)
    );

    lock_key_sender #(.KEY_BITS(3), .GAP(0), .RESP_WAIT(4)) u_b (
        .clk(clk), .reset(reset), .start(start), .code(code),
        .lock_unlock(lock_unlock), .lock_error(lock_error),
        .enter(b_enter), .keyin(b_keyin), .valid(b_valid),
        .lock_reset(b_lr), .busy(b_busy), .done(b_done),
        .pass(b_pass), .fail(b_fail), .timeout(b_to)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered just after a posedge; cycle 0 is the cycle that follows.
    task automatic run(input int n, input bit b, input logic [2:0] c0,
                       input logic [2:0] c1, input int rk, input int rc,
                       input bit hold);
        ev = '0; kv = '0; lv = '0; dv = '0;
        pv = '0; fv = '0; tv = '0; vv = '0;
        for (int k = 0; k < n; k++) begin
            start       = hold || (k == 0);
            code        = (k == 0) ? c0 : c1;
            lock_unlock = (rk == 1) && (k == rc);
            lock_error  = (rk == 2) && (k == rc);
            @(negedge clk);
            ev[k] = b ? b_enter : a_enter;
            kv[k] = b ? b_keyin : a_keyin;
            lv[k] = b ? b_lr    : a_lr;
            dv[k] = b ? b_done  : a_done;
            pv[k] = b ? b_pass  : a_pass;
            fv[k] = b ? b_fail  : a_fail;
            tv[k] = b ? b_to    : a_to;
            vv[k] = b ? b_valid : a_valid;
            @(posedge clk);
            #1;
        end
        start       = 1'b0;
        lock_unlock = 1'b0;
        lock_error  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; code = '0;
        lock_unlock = 1'b0; lock_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", 32'({a_enter, a_keyin, a_valid, a_lr, a_busy,
                          a_done, a_pass, a_fail, a_to}), 32'h0);
        chk("rst_b", 32'({b_enter, b_keyin, b_valid, b_lr, b_busy,
                          b_done, b_pass, b_fail, b_to}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: GAP=2, correct code 101, unlock in cycle 15
        run(20, 1'b0, 3'b101, 3'b000, 1, 15, 1'b0);
        chk("t1_enter", ev, 32'h0000_4444);
        chk("t1_keyin", kv, 32'h0000_0808);
        chk("t1_lrst",  lv, 32'h0000_0002);
        chk("t1_done",  dv, 32'h0001_0000);
        chk("t1_pass",  pv, 32'h000F_0000);
        chk("t1_fail",  fv, 32'h0);
        chk("t1_valid", vv, 32'h0000_FFFE);

        // 2: MSB wrong, lock answers error in cycle 15
        run(20, 1'b0, 3'b001, 3'b000, 2, 15, 1'b0);
        chk("t2_enter", ev, 32'h0000_4444);
        chk("t2_keyin", kv, 32'h0000_0800);
        chk("t2_fail",  fv, 32'h000F_0000);
        chk("t2_pass",  pv, 32'h0000_0001);

        // 3: GAP=0 instance, code 110, unlock in cycle 9
        run(24, 1'b1, 3'b110, 3'b000, 1, 9, 1'b0);
        chk("t3_enter", ev, 32'h0000_0154);
        chk("t3_keyin", kv, 32'h0000_0028);
        chk("t3_done",  dv, 32'h0000_0400);
        chk("t3_pass",  pv, 32'h00FF_FC00);

        // 4: no response at all, RESP cycles 15..18
        run(24, 1'b0, 3'b101, 3'b000, 0, 0, 1'b0);
        chk("t4_done",  dv, 32'h0008_0000);
        chk("t4_tout",  tv, 32'h00F8_0001);
        chk("t4_pass",  pv, 32'h0);
        chk("t4_fail",  fv, 32'h0);
        chk("t4_valid", vv, 32'h0007_FFFE);

        // 5: async reset while in GAPW (cycle 4)
        start = 1'b1; code = 3'b101;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_gapw", 32'({a_valid, a_enter, a_keyin, a_lr}), 32'h8);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst", 32'({a_enter, a_keyin, a_valid, a_lr, a_busy,
                           a_done, a_pass, a_fail, a_to}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run(20, 1'b0, 3'b101, 3'b000, 1, 15, 1'b0);
        chk("t5_enter", ev, 32'h0000_4444);
        chk("t5_done",  dv, 32'h0001_0000);
        chk("t5_pass",  pv, 32'h000F_0000);

        // 6: start held, code changed while busy
        run(22, 1'b0, 3'b101, 3'b010, 1, 15, 1'b1);
        chk("t6_lrst",  lv, 32'h0002_0002);
        chk("t6_keyin", kv, 32'h0000_0808);
        chk("t6_enter", ev, 32'h0004_4444);
        chk("t6_done",  dv, 32'h0001_0000);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
